hazard_ctrl: RTL and testbench

- Pipeline control unit for the five-stage MIPS-style pipeline: IF, ID, EX, MEM, WB.
- Generates these controls each cycle:
  - PC and IF/ID enables.
  - IF/ID flush.
  - ID/EX bubble insertion.
  - PC redirect on taken branch or jump.
- Forwarding selects for the EX-stage ALU operands are registered, so they arrive aligned with the instruction that enters EX.
- Sequences a shared multi-cycle multiply/divide unit: starts it, stalls ID while it is busy, releases the instruction on completion.

---
 rtl/hazard_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline control for the five-stage IF/ID/EX/MEM/WB pipeline.
// It detects load-use hazards, stalls ID behind the shared multi-cycle
// mul/div unit, redirects the PC on taken branches and jumps, and registers
// the EX operand forwarding selects so they line up with the instruction
// entering EX.
module hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_muldiv,
  input  logic       id_is_div,
  input  logic [4:0] ex_rw,
  input  logic       ex_regwr,
  input  logic       ex_memtoreg,
  input  logic [4:0] mem_rw,
  input  logic       mem_regwr,
  input  logic       ex_taken,
  output logic       pc_en,
  output logic       pc_redirect,
  output logic       if_id_en,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       md_start,
  output logic       md_busy,
  output logic       md_done
);

  // Counter preload values: the counter counts down to zero, so a unit that
  // is busy for N cycles is loaded with N-1.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;

  logic lu;
  logic stall;
  logic md_start_raw;
  logic md_busy_raw;
  logic md_done_raw;

  // Operand source for one register read: EX result wins over MEM result,
  // and $0 or an unused operand always reads the register file.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       uses,
    input logic [4:0] e_rw,
    input logic       e_wr,
    input logic [4:0] m_rw,
    input logic       m_wr
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (uses && (src != 5'd0)) begin
      if (e_wr && (e_rw == src)) begin
        sel = 2'd1;
      end else if (m_wr && (m_rw == src)) begin
        sel = 2'd2;
      end
    end
    return sel;
  endfunction

  // Load-use detection: a load in EX whose destination is read by ID cannot
  // be forwarded in time, so ID must wait one cycle.
  always_comb begin
    lu = 1'b0;
    if (ex_memtoreg && ex_regwr && (ex_rw != 5'd0)) begin
      if ((id_uses_rs && (ex_rw == id_rs)) || (id_uses_rt && (ex_rw == id_rt))) begin
        lu = 1'b1;
      end
    end
  end

  // Mul/div sequencer next state: start when ID holds a mul/div that is not
  // itself waiting on a load, count down while busy, then one DONE cycle in
  // which the ID instruction is released.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    md_start_raw = 1'b0;
    md_busy_raw  = 1'b0;
    md_done_raw  = 1'b0;
    case (state_q)
      IDLE: begin
        if (id_is_muldiv && !lu) begin
          md_start_raw = 1'b1;
          cnt_d        = id_is_div ? DIV_LOAD : MUL_LOAD;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        md_busy_raw = 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        md_busy_raw = 1'b1;
        md_done_raw = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stall and redirect controls; while reset is held the front end is frozen
  // and IF/ID and ID/EX are forced to NOPs.
  always_comb begin
    stall        = lu || (id_is_muldiv && (state_q != DONE));
    pc_en        = 1'b0;
    pc_redirect  = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b1;
    id_ex_bubble = 1'b1;
    md_start     = 1'b0;
    if (rst_n) begin
      pc_en        = !stall || ex_taken;
      pc_redirect  = ex_taken;
      if_id_en     = !stall;
      if_id_flush  = ex_taken && !stall;
      id_ex_bubble = stall;
      md_start     = md_start_raw;
    end
  end

  assign md_busy = md_busy_raw;
  assign md_done = md_done_raw;

  // Forwarding selects for the instruction about to enter EX; a bubble
  // carries no operands, so it gets register-file selects.
  always_comb begin
    fwd_a_d = 2'd0;
    fwd_b_d = 2'd0;
    if (!id_ex_bubble) begin
      fwd_a_d = fwd_sel(id_rs, id_uses_rs, ex_rw, ex_regwr, mem_rw, mem_regwr);
      fwd_b_d = fwd_sel(id_rt, id_uses_rt, ex_rw, ex_regwr, mem_rw, mem_regwr);
    end
  end

  // Forwarding select registers, aligned with the ID/EX pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= 2'd0;
      fwd_b_q <= 2'd0;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl with hand-computed values.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       id_is_muldiv;
  logic       id_is_div;
  logic [4:0] ex_rw;
  logic       ex_regwr;
  logic       ex_memtoreg;
  logic [4:0] mem_rw;
  logic       mem_regwr;
  logic       ex_taken;
  logic       pc_en;
  logic       pc_redirect;
  logic       if_id_en;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       md_start;
  logic       md_busy;
  logic       md_done;

  int n_cmp = 0;
  int n_err = 0;

  hazard_ctrl #(
    .MUL_CYCLES(4),
    .DIV_CYCLES(32),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt),
    .id_is_muldiv(id_is_muldiv),
    .id_is_div(id_is_div),
    .ex_rw(ex_rw),
    .ex_regwr(ex_regwr),
    .ex_memtoreg(ex_memtoreg),
    .mem_rw(mem_rw),
    .mem_regwr(mem_regwr),
    .ex_taken(ex_taken),
    .pc_en(pc_en),
    .pc_redirect(pc_redirect),
    .if_id_en(if_id_en),
    .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble),
    .fwd_a(fwd_a),
    .fwd_b(fwd_b),
    .md_start(md_start),
    .md_busy(md_busy),
    .md_done(md_done)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus();
    id_rs        = 5'd0;
    id_rt        = 5'd0;
    id_uses_rs   = 1'b0;
    id_uses_rt   = 1'b0;
    id_is_muldiv = 1'b0;
    id_is_div    = 1'b0;
    ex_rw        = 5'd0;
    ex_regwr     = 1'b0;
    ex_memtoreg  = 1'b0;
    mem_rw       = 5'd0;
    mem_regwr    = 1'b0;
    ex_taken     = 1'b0;
  endtask

  task automatic check_stall(input string tag, input logic stalled);
    check_output({tag, "_pc_en"}, 8'(pc_en), 8'(!stalled));
    check_output({tag, "_if_id_en"}, 8'(if_id_en), 8'(!stalled));
    check_output({tag, "_bubble"}, 8'(id_ex_bubble), 8'(stalled));
  endtask

  initial begin
    $display("[TB] start");
    apply_stimulus();
    rst_n        = 1'b0;
    ex_taken     = 1'b1;
    id_is_muldiv = 1'b1;
    #12;
    // Reset held: frozen front end, no redirect or start even when requested.
    check_output("rst_pc_en", 8'(pc_en), 8'd0);
    check_output("rst_if_id_en", 8'(if_id_en), 8'd0);
    check_output("rst_flush", 8'(if_id_flush), 8'd1);
    check_output("rst_bubble", 8'(id_ex_bubble), 8'd1);
    check_output("rst_redirect", 8'(pc_redirect), 8'd0);
    check_output("rst_md_start", 8'(md_start), 8'd0);
    check_output("rst_md_busy", 8'(md_busy), 8'd0);
    check_output("rst_fwd_a", 8'(fwd_a), 8'd0);
    check_output("rst_fwd_b", 8'(fwd_b), 8'd0);

    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus();
    #1;
    check_stall("idle", 1'b0);
    check_output("idle_flush", 8'(if_id_flush), 8'd0);

    // Load-use on rs: one stall cycle with a bubble, then MEM forward.
    @(negedge clk);
    ex_rw = 5'd5; ex_regwr = 1'b1; ex_memtoreg = 1'b1;
    id_rs = 5'd5; id_uses_rs = 1'b1;
    #1;
    check_stall("lu", 1'b1);
    @(posedge clk); #1;
    check_output("lu_fwd_a_bubble", 8'(fwd_a), 8'd0);
    @(negedge clk);
    ex_rw = 5'd0; ex_regwr = 1'b0; ex_memtoreg = 1'b0;
    mem_rw = 5'd5; mem_regwr = 1'b1;
    #1;
    check_stall("lu_after", 1'b0);
    @(posedge clk); #1;
    check_output("lu_fwd_a_mem", 8'(fwd_a), 8'd2);

    // Load writing $0 is never a hazard.
    @(negedge clk);
    apply_stimulus();
    ex_rw = 5'd0; ex_regwr = 1'b1; ex_memtoreg = 1'b1;
    id_rs = 5'd0; id_uses_rs = 1'b1;
    #1;
    check_stall("lu_r0", 1'b0);

    // Load-use on rt only.
    @(negedge clk);
    apply_stimulus();
    ex_rw = 5'd12; ex_regwr = 1'b1; ex_memtoreg = 1'b1;
    id_rt = 5'd12; id_uses_rt = 1'b1;
    #1;
    check_stall("lu_rt", 1'b1);

    // Back-to-back ALU ops: EX forward on rt beats a MEM match; rs via MEM.
    @(negedge clk);
    apply_stimulus();
    ex_rw = 5'd3; ex_regwr = 1'b1;
    mem_rw = 5'd3; mem_regwr = 1'b1;
    id_rt = 5'd3; id_uses_rt = 1'b1;
    id_rs = 5'd7; id_uses_rs = 1'b1;
    #1;
    check_stall("alu", 1'b0);
    @(posedge clk); #1;
    check_output("alu_fwd_b_ex", 8'(fwd_b), 8'd1);
    check_output("alu_fwd_a_none", 8'(fwd_a), 8'd0);

    @(negedge clk);
    mem_rw = 5'd7;
    #1;
    @(posedge clk); #1;
    check_output("alu_fwd_a_mem", 8'(fwd_a), 8'd2);
    check_output("alu_fwd_b_ex2", 8'(fwd_b), 8'd1);

    // Writes to $0 and unused operands never forward.
    @(negedge clk);
    apply_stimulus();
    ex_rw = 5'd0; ex_regwr = 1'b1;
    id_rt = 5'd0; id_uses_rt = 1'b1;
    id_rs = 5'd9; id_uses_rs = 1'b0;
    mem_rw = 5'd9; mem_regwr = 1'b1;
    #1;
    @(posedge clk); #1;
    check_output("r0_fwd_b", 8'(fwd_b), 8'd0);
    check_output("unused_fwd_a", 8'(fwd_a), 8'd0);

    // Multiply: start at cycle 0, busy 1..5, done at 5, stall 0..4.
    @(negedge clk);
    apply_stimulus();
    id_is_muldiv = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check_output($sformatf("mul_start_c%0d", c), 8'(md_start), 8'(c == 0));
      check_output($sformatf("mul_busy_c%0d", c), 8'(md_busy), 8'(c >= 1));
      check_output($sformatf("mul_done_c%0d", c), 8'(md_done), 8'(c == 5));
      check_output($sformatf("mul_pc_en_c%0d", c), 8'(pc_en), 8'(c == 5));
      check_output($sformatf("mul_bubble_c%0d", c), 8'(id_ex_bubble), 8'(c != 5));
    end
    @(negedge clk);
    apply_stimulus();
    #1;
    check_output("mul_after_busy", 8'(md_busy), 8'd0);
    check_stall("mul_after", 1'b0);

    // Divide: done at cycle 33.
    @(negedge clk);
    id_is_muldiv = 1'b1; id_is_div = 1'b1;
    for (int c = 0; c < 34; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check_output($sformatf("div_done_c%0d", c), 8'(md_done), 8'(c == 33));
      check_output($sformatf("div_busy_c%0d", c), 8'(md_busy), 8'(c >= 1));
      check_output($sformatf("div_pc_en_c%0d", c), 8'(pc_en), 8'(c == 33));
    end
    @(negedge clk);
    apply_stimulus();
    #1;
    check_output("div_after_busy", 8'(md_busy), 8'd0);

    // Load-use blocks the mul/div start and the FSM stays idle.
    @(negedge clk);
    id_is_muldiv = 1'b1;
    id_rs = 5'd4; id_uses_rs = 1'b1;
    ex_rw = 5'd4; ex_regwr = 1'b1; ex_memtoreg = 1'b1;
    #1;
    check_output("lu_md_start", 8'(md_start), 8'd0);
    check_stall("lu_md", 1'b1);
    @(posedge clk); #1;
    check_output("lu_md_busy", 8'(md_busy), 8'd0);
    @(negedge clk);
    apply_stimulus();

    // Taken branch with no stall: redirect and flush the wrong-path fetch.
    ex_taken = 1'b1;
    #1;
    check_output("br_redirect", 8'(pc_redirect), 8'd1);
    check_output("br_pc_en", 8'(pc_en), 8'd1);
    check_output("br_flush", 8'(if_id_flush), 8'd1);
    check_output("br_if_id_en", 8'(if_id_en), 8'd1);

    // Taken branch during a multiply start: keep the delay slot, FSM starts.
    @(negedge clk);
    ex_taken = 1'b1; id_is_muldiv = 1'b1;
    #1;
    check_output("brmd_start", 8'(md_start), 8'd1);
    check_output("brmd_redirect", 8'(pc_redirect), 8'd1);
    check_output("brmd_pc_en", 8'(pc_en), 8'd1);
    check_output("brmd_flush", 8'(if_id_flush), 8'd0);
    check_output("brmd_if_id_en", 8'(if_id_en), 8'd0);
    @(negedge clk);
    ex_taken = 1'b0;
    #1;
    check_output("brmd_busy", 8'(md_busy), 8'd1);
    repeat (4) @(negedge clk);
    #1;
    check_output("brmd_done", 8'(md_done), 8'd1);
    @(negedge clk);
    apply_stimulus();

    // Async reset clears a live forwarding select immediately.
    ex_rw = 5'd9; ex_regwr = 1'b1;
    id_rs = 5'd9; id_uses_rs = 1'b1;
    @(posedge clk); #1;
    check_output("arst_fwd_a_pre", 8'(fwd_a), 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("arst_fwd_a", 8'(fwd_a), 8'd0);
    check_output("arst_pc_en", 8'(pc_en), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus();

    // Divide interrupted by reset while BUSY with cnt=10 (cycle 22).
    @(negedge clk);
    id_is_muldiv = 1'b1; id_is_div = 1'b1;
    repeat (22) @(negedge clk);
    #1;
    check_output("divrst_busy_pre", 8'(md_busy), 8'd1);
    check_output("divrst_done_pre", 8'(md_done), 8'd0);
    rst_n = 1'b0;
    #1;
    check_output("divrst_busy", 8'(md_busy), 8'd0);
    check_output("divrst_fwd_a", 8'(fwd_a), 8'd0);
    check_output("divrst_pc_en", 8'(pc_en), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus();
    #1;
    check_output("divrst_rel_pc_en", 8'(pc_en), 8'd1);
    @(posedge clk); #1;
    check_output("divrst_idle_busy", 8'(md_busy), 8'd0);
    check_output("divrst_idle_done", 8'(md_done), 8'd0);

    // A fresh multiply after the reset takes its full latency again.
    @(negedge clk);
    id_is_muldiv = 1'b1;
    #1;
    check_output("post_rst_start", 8'(md_start), 8'd1);
    repeat (5) @(negedge clk);
    #1;
    check_output("post_rst_done", 8'(md_done), 8'd1);
    @(negedge clk);
    apply_stimulus();
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
